// File: rtl/key_conditioner_pkg.sv
// Shared types and constants for the key conditioner.
// Optional feature macro: KEY_CONDITIONER_KEY_REPEAT_EN (auto-repeat press pulses).
package key_conditioner_pkg;

    // Per-key debounce state. Exposed by each channel so checkers can bind to it.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    // Default timing at a 50 MHz clock.
    localparam int          DEFAULT_NUM_KEYS        = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1000000;  // 20 ms
    localparam int unsigned DEFAULT_REPEAT_DELAY    = 32'd25000000; // 500 ms
    localparam int unsigned DEFAULT_REPEAT_PERIOD   = 32'd5000000;  // 100 ms

    // Bits needed for a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int unsigned max_val);
        return (max_val < 32'd2) ? 1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchroniser, four-state debounce FSM and,
// when KEY_CONDITIONER_KEY_REPEAT_EN is defined, an auto-repeat counter.
//
// Handshake: none. press_pulse/release_pulse are registered one-cycle
// strobes meant to be used as synchronous enables; there is no ready/ack,
// a strobe is simply valid for exactly the cycle it is high.
module key_debounce_channel
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef KEY_CONDITIONER_KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output key_state_e state,
    output logic       press_pulse,
    output logic       release_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync_meta;
    logic          sync_s;
    key_state_e    state_q;
    key_state_e    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_accept;
    logic          press_d;
    logic          release_d;
    logic          press_q;
    logic          release_q;

    // Two-flop synchroniser; presets to "released" so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_s    <= 1'b1;
        end else begin
            sync_meta <= key_n;
            sync_s    <= sync_meta;
        end
    end

    // State, debounce counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next state: a level change is accepted only after the counter reaches
    // DEBOUNCE_CYCLES with the new level still present; any bounce back aborts.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_accept = 1'b0;
        release_d    = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (!sync_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (sync_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d      = PRESSED;
                    cnt_d        = '0;
                    press_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (sync_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEY_CONDITIONER_KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(REP_MAX);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] REP_ONE   = RW'(1);

    logic [RW-1:0] rep_cnt_q;
    logic [RW-1:0] rep_cnt_d;
    logic          rep_armed_q;
    logic          rep_armed_d;
    logic          rep_fire;
    logic [RW-1:0] rep_limit;

    // Repeat counter registers; armed selects the period after the first repeat.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    // Count only while steadily held; RELEASE_WAIT pauses, RELEASED clears.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        rep_limit   = rep_armed_q ? REP_NEXT : REP_FIRST;
        if (state_q == PRESSED && !sync_s) begin
            if (rep_cnt_q + REP_ONE == rep_limit) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_ONE;
            end
        end else if (state_q == RELEASED) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end
    end

    assign press_d = press_accept | rep_fire;
`else
    assign press_d = press_accept;
`endif

    assign state         = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner top: NUM_KEYS independent debounce channels that turn raw
// active-low buttons into a clean level plus press/release strobes.
// Optional feature macro: KEY_CONDITIONER_KEY_REPEAT_EN (auto-repeat press pulses).
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int          NUM_KEYS        = DEFAULT_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    key_state_e chan_state [NUM_KEYS];

    // Zero timing values are meaningless; the named empty scope marks such a
    // configuration in the elaborated hierarchy rather than silently building it.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_illegal_timing
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_CONDITIONER_KEY_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .key_n         (key_n[i]),
            .state         (chan_state[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );

        // The debounced level is simply "in the pressed half" of the FSM.
        assign key_down[i] = (chan_state[i] == PRESSED) || (chan_state[i] == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short timing (debounce 4, repeat 10/3).
module tb_key_conditioner;

    localparam int NK  = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_down;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3*NK-1:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .key_down      (key_down),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the synchronised sample s lags key_n by two edges; a
    // key's debounced level flips once the opposite level has been seen for
    // DEB+1 consecutive samples. Repeats are counted in steady-hold samples.
    logic [NK-1:0] m_meta;
    logic [NK-1:0] m_s;
    logic [NK-1:0] m_lvl;
    int            m_run  [NK];
    int            m_hold [NK];

    always @(posedge clk) begin : model
        logic [NK-1:0] p;
        logic [NK-1:0] r;
        p = '0;
        r = '0;
        if (reset) begin
            m_meta = '1;
            m_s    = '1;
            m_lvl  = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k]  = 0;
                m_hold[k] = 0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                if (~m_s[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB + 1) begin
                        m_lvl[k] = ~m_lvl[k];
                        m_run[k] = 0;
                        if (m_lvl[k]) p[k] = 1'b1;
                        else begin
                            r[k]      = 1'b1;
                            m_hold[k] = 0;
                        end
                    end
                end else begin
`ifdef KEY_CONDITIONER_KEY_REPEAT_EN
                    if (m_lvl[k] && m_run[k] == 0) begin
                        m_hold[k]++;
                        if (m_hold[k] >= RD && (m_hold[k] - RD) % RP == 0) p[k] = 1'b1;
                    end
`endif
                    m_run[k] = 0;
                end
            end
            m_s    = m_meta;
            m_meta = key_n;
        end
        exp_q.push_back({m_lvl, p, r});
    end

    // Scoreboard: every cycle, DUT outputs against the model.
    always @(negedge clk) begin : scoreboard
        logic [3*NK-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {20'd0, key_down, press_pulse, release_pulse}, {20'd0, e});
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int rem [NK];

    initial begin : stim
        int cnt;
        int first;
        reset = 1'b1;
        key_n = '1;
        cycles(3);
        check("reset_down", {28'd0, key_down}, 32'h0);
        check("reset_press", {28'd0, press_pulse}, 32'h0);
        check("reset_release", {28'd0, release_pulse}, 32'h0);
        reset = 1'b0;
        cycles(2);

        // Clean press on key 0: pulse exactly 6 edges after the first low sample.
        key_n[0] = 1'b0;
        cycles(6);
        check("press_not_early", {28'd0, press_pulse}, 32'h0);
        cycles(1);
        check("press_pulse", {28'd0, press_pulse}, 32'h1);
        check("press_down", {28'd0, key_down}, 32'h1);
        cycles(1);
        check("press_one_cycle", {28'd0, press_pulse}, 32'h0);
        check("press_down_held", {28'd0, key_down}, 32'h1);

        // Two-cycle high glitch while held: nothing changes.
        key_n[0] = 1'b1;
        cycles(2);
        key_n[0] = 1'b0;
        cycles(8);
        check("glitch_down", {28'd0, key_down}, 32'h1);

        // Release key 0.
        key_n[0] = 1'b1;
        cycles(7);
        check("release_pulse", {28'd0, release_pulse}, 32'h1);
        check("release_down", {28'd0, key_down}, 32'h0);
        cycles(1);
        check("release_one_cycle", {28'd0, release_pulse}, 32'h0);
        cycles(3);

        // Bounce on key 1: low 3, high 1, low 3, high.
        cnt = 0;
        key_n[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin cycles(1); if (press_pulse[1]) cnt++; end
        key_n[1] = 1'b1;
        for (int i = 0; i < 1; i++) begin cycles(1); if (press_pulse[1]) cnt++; end
        key_n[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin cycles(1); if (press_pulse[1]) cnt++; end
        key_n[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin cycles(1); if (press_pulse[1]) cnt++; end
        check("bounce_no_press", cnt, 0);
        check("bounce_down", {28'd0, key_down}, 32'h0);

        // Simultaneous press and release of all keys.
        key_n = '0;
        cycles(7);
        check("simul_press", {28'd0, press_pulse}, 32'hF);
        key_n = '1;
        cycles(7);
        check("simul_release", {28'd0, release_pulse}, 32'hF);
        cycles(3);

        // Reset in PRESS_WAIT with cnt=2, key held through reset release.
        key_n[0] = 1'b0;
        cycles(4);
        reset = 1'b1;
        cycles(1);
        check("midreset_down", {28'd0, key_down}, 32'h0);
        check("midreset_press", {28'd0, press_pulse}, 32'h0);
        reset = 1'b0;
        cycles(7);
        check("held_reset_press", {28'd0, press_pulse}, 32'h1);

        // Hold 30 more cycles: repeats at +10,+13,...,+28 only with the feature.
        cnt   = 0;
        first = -1;
        for (int i = 1; i <= 30; i++) begin
            cycles(1);
            if (press_pulse[0]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
`ifdef KEY_CONDITIONER_KEY_REPEAT_EN
        check("repeat_count", cnt, 7);
        check("repeat_first", first, 10);
`else
        check("repeat_count", cnt, 0);
        check("repeat_first", first, -1);
`endif
        check("repeat_down", {28'd0, key_down}, 32'h1);
        key_n[0] = 1'b1;
        cycles(10);

        // Random phase: per-key mix of short bounces and stable holds, rare resets.
        for (int k = 0; k < NK; k++) rem[k] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    rem[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4)
                                                          : $urandom_range(5, 30);
                end
            end
            reset = ($urandom_range(0, 399) == 0);
            cycles(1);
        end
        reset = 1'b0;
        key_n = '1;
        cycles(20);
        check("final_down", {28'd0, key_down}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
